// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Writeback controller for the 32 x 32-bit register file. Shares the single
// register-file write port between the ALU and multiply/divide writeback
// paths using round-robin arbitration. Keeps a pending-write scoreboard so
// issue logic can stall reads of registers whose results are still in flight.
//
// Ports:
//   clock              rising-edge clock
//   ctrl_reset         asynchronous, active-low reset
//   alu_valid/ready    ALU writeback handshake; alu_reg/alu_data = dest/data
//   md_valid/ready     multdiv writeback handshake; md_reg/md_data = dest/data
//   rsv_valid/rsv_reg  issue stage reserves a destination register
//   rsv_ready          reservation accepted (combinational)
//   chk_regA/chk_regB  source registers read at issue
//   stall              a source register has a pending write (combinational)
//   ctrl_writeEnable   registered write strobe to the register file
//   ctrl_writeReg      registered write address
//   data_writeReg      registered write data
//   busy               scoreboard; bit r set = register r has a pending write
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                            clock,
   input  logic                            ctrl_reset,
   input  logic                            alu_valid,
   output logic                            alu_ready,
   input  logic [REG_ADDR_WIDTH-1:0]       alu_reg,
   input  logic [DATA_WIDTH-1:0]           alu_data,
   input  logic                            md_valid,
   output logic                            md_ready,
   input  logic [REG_ADDR_WIDTH-1:0]       md_reg,
   input  logic [DATA_WIDTH-1:0]           md_data,
   input  logic                            rsv_valid,
   input  logic [REG_ADDR_WIDTH-1:0]       rsv_reg,
   output logic                            rsv_ready,
   input  logic [REG_ADDR_WIDTH-1:0]       chk_regA,
   input  logic [REG_ADDR_WIDTH-1:0]       chk_regB,
   output logic                            stall,
   output logic                            ctrl_writeEnable,
   output logic [REG_ADDR_WIDTH-1:0]       ctrl_writeReg,
   output logic [DATA_WIDTH-1:0]           data_writeReg,
   output logic [(2**REG_ADDR_WIDTH)-1:0]  busy
);

   localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

   // Round-robin pointer: 1 = ALU wins the next contested cycle.
   logic                      alu_pri_q;
   logic                      contest;
   logic                      wr_fire;
   logic [REG_ADDR_WIDTH-1:0] sel_reg;
   logic [DATA_WIDTH-1:0]     sel_data;
   logic [NUM_REGS-1:0]       busy_clr;
   logic [NUM_REGS-1:0]       busy_set;
   logic [NUM_REGS-1:0]       busy_nxt;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_WIDTH-1:0] idx);
      logic [NUM_REGS-1:0] one;
      one = {{(NUM_REGS-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   // ---- arbitration (combinational, no path through data inputs) ----
   always_comb begin
      contest   = alu_valid & md_valid;
      alu_ready = alu_valid & (~md_valid | alu_pri_q);
      md_ready  = md_valid  & (~alu_valid | ~alu_pri_q);
      wr_fire   = alu_ready | md_ready;
      sel_reg   = alu_ready ? alu_reg  : md_reg;
      sel_data  = alu_ready ? alu_data : md_data;
   end

   // ---- scoreboard lookup (combinational) ----
   always_comb begin
      // busy[0] is held at 0, but the explicit r0 term keeps rsv_ready
      // independent of that invariant.
      rsv_ready = ~busy[rsv_reg] | (rsv_reg == '0);
      stall     = ((chk_regA != '0) & busy[chk_regA]) |
                  ((chk_regB != '0) & busy[chk_regB]);
   end

   always_comb begin
      busy_clr = ctrl_writeEnable ? onehot(ctrl_writeReg) : '0;
      busy_set = (rsv_valid & rsv_ready & (rsv_reg != '0)) ? onehot(rsv_reg) : '0;
      // A reservation of a retiring register is refused by rsv_ready, so
      // set and clear never collide on the same bit.
      busy_nxt    = (busy & ~busy_clr) | busy_set;
      busy_nxt[0] = 1'b0;
   end

   // ---- stage boundary: accept edge -> registered write port ----
   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         alu_pri_q        <= 1'b1;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
         busy             <= '0;
      end else begin
         // Pointer moves only on contested cycles: the loser is favoured next.
         if (contest)
            alu_pri_q <= ~alu_pri_q;
         // Writes to r0 are consumed but never strobed into the register file.
         ctrl_writeEnable <= wr_fire & (sel_reg != '0);
         if (wr_fire) begin
            ctrl_writeReg <= sel_reg;
            data_writeReg <= sel_data;
         end
         busy <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        alu_valid, md_valid, rsv_valid;
   logic        alu_ready, md_ready, rsv_ready, stall;
   logic [4:0]  alu_reg, md_reg, rsv_reg, chk_regA, chk_regB;
   logic [31:0] alu_data, md_data;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [31:0] busy;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   logic [31:0] m_busy;
   logic        m_alu_first;
   logic        m_we;
   logic [4:0]  m_wreg;
   logic [31:0] m_wdata;

   always #5 clock = ~clock;

   regfile_wb_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clock(clock), .ctrl_reset(ctrl_reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
      .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rsv_ready(rsv_ready),
      .chk_regA(chk_regA), .chk_regB(chk_regB), .stall(stall),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .busy(busy)
   );

   // Expected combinational outputs from the arbitration and scoreboard rules
   function automatic logic exp_alu_rdy();
      return alu_valid && (!md_valid || m_alu_first);
   endfunction

   function automatic logic exp_md_rdy();
      return md_valid && (!alu_valid || !m_alu_first);
   endfunction

   function automatic logic exp_rsv_rdy();
      return (rsv_reg == 5'd0) || !m_busy[rsv_reg];
   endfunction

   function automatic logic exp_stall();
      return (chk_regA != 5'd0 && m_busy[chk_regA]) || (chk_regB != 5'd0 && m_busy[chk_regB]);
   endfunction

   function automatic logic [31:0] next_busy();
      logic [31:0] b;
      b = m_busy;
      if (m_we) b[m_wreg] = 1'b0;
      if (rsv_valid && exp_rsv_rdy() && rsv_reg != 5'd0) b[rsv_reg] = 1'b1;
      return b;
   endfunction

   always @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         m_busy      <= '0;
         m_alu_first <= 1'b1;
         m_we        <= 1'b0;
         m_wreg      <= '0;
         m_wdata     <= '0;
      end else begin
         if (exp_alu_rdy()) begin
            m_wreg  <= alu_reg;
            m_wdata <= alu_data;
         end else if (exp_md_rdy()) begin
            m_wreg  <= md_reg;
            m_wdata <= md_data;
         end
         m_we <= (exp_alu_rdy() && alu_reg != 5'd0) || (exp_md_rdy() && md_reg != 5'd0);
         // After a contest the loser gets priority.
         if (alu_valid && md_valid) m_alu_first <= exp_md_rdy();
         m_busy <= next_busy();
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("alu_ready", 64'(alu_ready), 64'(exp_alu_rdy()));
      chk("md_ready", 64'(md_ready), 64'(exp_md_rdy()));
      chk("rsv_ready", 64'(rsv_ready), 64'(exp_rsv_rdy()));
      chk("stall", 64'(stall), 64'(exp_stall()));
      chk("writeEnable", 64'(ctrl_writeEnable), 64'(m_we));
      chk("writeReg", 64'(ctrl_writeReg), 64'(m_wreg));
      chk("writeData", 64'(data_writeReg), 64'(m_wdata));
      chk("busy", 64'(busy), 64'(m_busy));
   endtask

   task automatic cyc();
      @(negedge clock);
      compare_all();
   endtask

   task automatic adv();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 0; md_valid = 0; rsv_valid = 0;
      alu_reg = 0; md_reg = 0; rsv_reg = 0; chk_regA = 0; chk_regB = 0;
      alu_data = 0; md_data = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ctrl_reset = 1'b0;
      idle_inputs();
      #2;
      chk("rst_we", 64'(ctrl_writeEnable), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", 64'(data_writeReg), 64'd0);
      #10 ctrl_reset = 1'b1;
      adv();

      // Single ALU write
      alu_valid = 1; alu_reg = 5; alu_data = 32'hDEADBEEF;
      cyc(); chk("t1_alu_ready", 64'(alu_ready), 64'd1);
      adv(); alu_valid = 0;
      cyc();
      chk("t1_we", 64'(ctrl_writeEnable), 64'd1);
      chk("t1_reg", 64'(ctrl_writeReg), 64'd5);
      chk("t1_data", 64'(data_writeReg), 64'hDEADBEEF);
      adv();
      cyc(); chk("t1_we_off", 64'(ctrl_writeEnable), 64'd0);
      adv();

      // Contested round-robin
      alu_valid = 1; alu_reg = 3; alu_data = 32'h33;
      md_valid = 1; md_reg = 7; md_data = 32'h77;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rr_alu_ready", 64'(alu_ready), 64'((i % 2) == 0));
         chk("rr_md_ready", 64'(md_ready), 64'((i % 2) == 1));
         if (i > 0) chk("rr_strobe_reg", 64'(ctrl_writeReg), (i % 2 == 1) ? 64'd3 : 64'd7);
         adv();
      end
      alu_valid = 0; md_valid = 0;
      cyc(); chk("rr_last_reg", 64'(ctrl_writeReg), 64'd7);
      adv();

      // Reservation, stall, retirement
      rsv_valid = 1; rsv_reg = 9;
      cyc(); chk("sb_rsv_ready", 64'(rsv_ready), 64'd1);
      adv(); rsv_valid = 0; chk_regA = 9;
      cyc();
      chk("sb_stall", 64'(stall), 64'd1);
      chk("sb_busy9", 64'(busy[9]), 64'd1);
      md_valid = 1; md_reg = 9; md_data = 32'h9999;
      adv(); md_valid = 0;
      cyc();
      chk("sb_strobe_we", 64'(ctrl_writeEnable), 64'd1);
      chk("sb_stall_strobe", 64'(stall), 64'd1);
      adv();
      cyc();
      chk("sb_stall_drop", 64'(stall), 64'd0);
      chk("sb_busy9_clr", 64'(busy[9]), 64'd0);

      // Reservation colliding with retirement
      rsv_valid = 1; rsv_reg = 9;
      adv(); rsv_valid = 0; md_valid = 1; md_reg = 9; md_data = 32'h1;
      cyc(); adv();
      md_valid = 0; rsv_valid = 1; rsv_reg = 9;
      cyc(); chk("col_rsv_ready", 64'(rsv_ready), 64'd0);
      adv(); rsv_valid = 0;
      cyc(); chk("col_busy9", 64'(busy[9]), 64'd0);

      // Register 0
      alu_valid = 1; alu_reg = 0; alu_data = 32'h1234;
      cyc(); chk("r0_ready", 64'(alu_ready), 64'd1);
      adv(); alu_valid = 0; rsv_valid = 1; rsv_reg = 0;
      cyc();
      chk("r0_we", 64'(ctrl_writeEnable), 64'd0);
      chk("r0_rsv_ready", 64'(rsv_ready), 64'd1);
      adv(); rsv_valid = 0; chk_regA = 0;
      cyc();
      chk("r0_busy", 64'(busy), 64'd0);
      chk("r0_stall", 64'(stall), 64'd0);
      adv();

      // Async reset mid-stream
      ctrl_reset = 0; #2 ctrl_reset = 1;
      alu_valid = 1; alu_reg = 1; md_valid = 1; md_reg = 2; rsv_valid = 1; rsv_reg = 5;
      cyc(); chk("ar_first_alu", 64'(alu_ready), 64'd1);
      adv(); alu_valid = 0; md_valid = 0; rsv_reg = 9;
      cyc(); adv();
      rsv_valid = 0; alu_valid = 1; alu_reg = 3; alu_data = 32'hCAFE;
      cyc(); chk("ar_busy_pre", 64'(busy), 64'h220);
      adv();
      alu_valid = 1; alu_reg = 4; md_valid = 1; md_reg = 6;
      #2 ctrl_reset = 0;
      #1;
      chk("ar_we", 64'(ctrl_writeEnable), 64'd0);
      chk("ar_reg", 64'(ctrl_writeReg), 64'd0);
      chk("ar_data", 64'(data_writeReg), 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_alu_pri", 64'(alu_ready), 64'd1);
      cyc();
      #1 ctrl_reset = 1;
      adv();
      cyc();
      chk("ar_post_we", 64'(ctrl_writeEnable), 64'd1);
      chk("ar_post_reg", 64'(ctrl_writeReg), 64'd4);
      adv();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         alu_valid = ($urandom_range(0, 9) < 6);
         md_valid  = ($urandom_range(0, 9) < 5);
         alu_reg   = 5'($urandom_range(0, 31));
         md_reg    = 5'($urandom_range(0, 31));
         alu_data  = $urandom;
         md_data   = $urandom;
         rsv_valid = ($urandom_range(0, 9) < 5);
         rsv_reg   = 5'($urandom_range(0, 31));
         chk_regA  = 5'($urandom_range(0, 31));
         chk_regB  = 5'($urandom_range(0, 31));
         if (n == 300) begin
            #3 ctrl_reset = 0;
            #1 compare_all();
            #1 ctrl_reset = 1;
         end
         cyc();
         adv();
      end

      idle_inputs();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
